maxnet_controller: RTL
======================

// Module: maxnet_controller
// PURPOSE
//  Sequences the four-neuron Maxnet competition over the four pipelined process units (PUs).
//  Holds the activation vector and drives it to the x1..x4 inputs of every PU; each PU has a fixed weight row.
//  Each iteration waits out the PU pipeline, writes the four ReLU outputs back and counts survivors.
//  Stops on a single survivor, all-zero, or the iteration limit.
// PARAMETERS
//  PIPE_LAT  3   PU latency in cycles (input reg -> product reg -> result reg)
//  MAX_ITER  63  iteration limit before timeout; range 1..2^ITER_W-1
//  ITER_W    6   width of the iteration counter
// PORTS
//  clk           in   1       system clock, rising edge
//  rst           in   1       synchronous, active-high reset
//  start         in   1       begin a run; sampled only in IDLE
//  init_a1..4    in   32      initial activations (IEEE-754 single), captured on accepted start
//  pu_out1..4    in   32      PU j result (ReLU output, never negative)
//  act1..4       out  32      current activation vector, fanned out to x1..x4 of all PUs
//  busy          out  1       high in RUN and CHECK
//  done          out  1       one-cycle pulse when a run ends
//  winner        out  2       index 0..3 of the surviving neuron
//  winner_valid  out  1       exactly one nonzero activation at end of run
//  timeout       out  1       run ended because the iteration limit was reached
//  iter_count    out  ITER_W  iterations completed in the current/last run
// BEHAVIOUR
//  Reset: state=IDLE; act1..4, iter_count, winner = 0; busy, done, winner_valid, timeout = 0.
//  Zero test: the value is zero iff bits[30:0]==0, so both +0 and -0 count as zero.
//  IDLE: on start=1, load act_j<=init_a_j, clear iter_count, winner_valid, timeout and wait_cnt, then go to RUN.
//    start in any other state is ignored.
//  RUN: act1..4 held constant; wait_cnt increments by 1 each cycle, starting from 0 on entry.
//    When wait_cnt==PIPE_LAT: capture act_j<=pu_out_j, iter_count<=iter_count+1, then go to CHECK.
//    Result: one RUN visit = PIPE_LAT+1 cycles.
//  CHECK: nz = number of nonzero act_j.
//    nz==1 -> winner=that index, winner_valid=1, go to DONE.
//    nz==0 -> winner_valid=0, winner=0, go to DONE.
//    nz>1 and iter_count==MAX_ITER -> timeout=1, winner=lowest nonzero index, winner_valid=0, go to DONE.
//    Otherwise clear wait_cnt and go to RUN.
//  DONE: done=1 for exactly this one cycle, then go to IDLE.
//    winner, winner_valid, timeout, iter_count and act hold until the next accepted start.
//  At least one iteration always runs, even if the initial vector already has a single nonzero.
//  Timing: start sampled at edge E0. The first CHECK is entered at E0+PIPE_LAT+1.
//    done is high in the cycle after edge E0+PIPE_LAT+2 (single-iteration run).
//    Each additional iteration adds PIPE_LAT+2 cycles.
//  rst during a run: immediate return to IDLE with reset values; no done pulse.
//  The controller does no arithmetic on the floats; it only copies bits and tests for zero.
// TESTING
//  Bench model: PU with weights 1.0 (diagonal) and -0.2 (off-diagonal), PIPE_LAT=3, ReLU on output.
//  1) init (1.0,0,0,0) [0x3F800000,0,0,0], start -> done 5 cycles after start edge.
//     Expect iter_count=1, winner=0, winner_valid=1, timeout=0, act1=0x3F800000.
//  2) init (0.2,0.4,0.6,0.8) -> winner=3, winner_valid=1, timeout=0.
//     act and iter_count match the golden C model bit-exact.
//  3) init all 0 -> done after 1 iteration; winner_valid=0, timeout=0, winner=0.
//  4) init all 0.5 (0x3F000000) -> values decay symmetrically and never reach zero.
//     Expect timeout=1, iter_count=MAX_ITER, winner=0, winner_valid=0.
//     done is 63*5 cycles after start (63 iterations x (PIPE_LAT+2) cycles).
//  5) pulse start again during RUN -> ignored: act and iter_count unaffected, exactly one done.
//  6) assert rst during the second RUN -> next cycle IDLE, act=0, busy=0, no done.
//     A following start runs normally.

Source files
------------

// File: rtl/maxnet_controller.sv
// Maxnet competition sequencer: drives the activation vector to the PUs, waits out the
// PU pipeline, writes the ReLU results back and stops on one survivor, none, or the limit.
module maxnet_controller #(
    parameter int PIPE_LAT = 3,
    parameter int MAX_ITER = 63,
    parameter int ITER_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       init_a1,
    input  logic [31:0]       init_a2,
    input  logic [31:0]       init_a3,
    input  logic [31:0]       init_a4,
    input  logic [31:0]       pu_out1,
    input  logic [31:0]       pu_out2,
    input  logic [31:0]       pu_out3,
    input  logic [31:0]       pu_out4,
    output logic [31:0]       act1,
    output logic [31:0]       act2,
    output logic [31:0]       act3,
    output logic [31:0]       act4,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner,
    output logic              winner_valid,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);
    // state | meaning
    // IDLE  | waiting for start; results of the last run held
    // RUN   | activations held on the PU inputs while the pipeline fills
    // CHECK | count nonzero activations, decide stop or iterate
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    localparam int                WAIT_W    = $clog2(PIPE_LAT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PIPE_LAT);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER);

    state_t             state, state_nx;
    logic [3:0][31:0]   act_q, act_nx;
    logic [3:0][31:0]   init_v, pu_v;
    logic [WAIT_W-1:0]  wait_q, wait_nx;
    logic [ITER_W-1:0]  iter_q, iter_nx;
    logic [1:0]         winner_q, winner_nx;
    logic               wv_q, wv_nx;
    logic               to_q, to_nx;
    logic [3:0]         nz_mask;
    logic [2:0]         nz_cnt;
    logic [1:0]         low_idx;

    assign init_v = {init_a4, init_a3, init_a2, init_a1};
    assign pu_v   = {pu_out4, pu_out3, pu_out2, pu_out1};

    // Sign bit ignored so that -0 counts as zero.
    always_comb begin
        nz_mask = '0;
        low_idx = '0;
        for (int j = 0; j < 4; j++) nz_mask[j] = |act_q[j][30:0];
        for (int j = 3; j >= 0; j--) if (nz_mask[j]) low_idx = 2'(j);
        nz_cnt = {2'b00, nz_mask[0]} + {2'b00, nz_mask[1]}
               + {2'b00, nz_mask[2]} + {2'b00, nz_mask[3]};
    end

    always_comb begin
        state_nx  = state;
        act_nx    = act_q;
        wait_nx   = wait_q;
        iter_nx   = iter_q;
        winner_nx = winner_q;
        wv_nx     = wv_q;
        to_nx     = to_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    act_nx   = init_v;
                    iter_nx  = '0;
                    wv_nx    = 1'b0;
                    to_nx    = 1'b0;
                    wait_nx  = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (wait_q == WAIT_LAST) begin
                    act_nx   = pu_v;
                    iter_nx  = iter_q + 1'b1;
                    state_nx = CHECK;
                end else begin
                    wait_nx = wait_q + 1'b1;
                end
            end
            CHECK: begin
                if (nz_cnt == 3'd1) begin
                    winner_nx = low_idx;
                    wv_nx     = 1'b1;
                    state_nx  = DONE;
                end else if (nz_cnt == 3'd0) begin
                    winner_nx = '0;
                    wv_nx     = 1'b0;
                    state_nx  = DONE;
                end else if (iter_q == ITER_LAST) begin
                    to_nx     = 1'b1;
                    winner_nx = low_idx;
                    wv_nx     = 1'b0;
                    state_nx  = DONE;
                end else begin
                    wait_nx  = '0;
                    state_nx = RUN;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            act_q    <= '0;
            wait_q   <= '0;
            iter_q   <= '0;
            winner_q <= '0;
            wv_q     <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            act_q    <= act_nx;
            wait_q   <= wait_nx;
            iter_q   <= iter_nx;
            winner_q <= winner_nx;
            wv_q     <= wv_nx;
            to_q     <= to_nx;
        end
    end

    assign act1         = act_q[0];
    assign act2         = act_q[1];
    assign act3         = act_q[2];
    assign act4         = act_q[3];
    assign busy         = (state == RUN) || (state == CHECK);
    assign done         = (state == DONE);
    assign winner       = winner_q;
    assign winner_valid = wv_q;
    assign timeout      = to_q;
    assign iter_count   = iter_q;

endmodule
